program_out_monitor: RTL and testbench

- Consumer stage directly downstream of the multi-cycle CPU; watches the CPU's two 16-bit result buses, program_out and program_out2.
- Every change of the pair {program_out2, program_out} is captured, tagged with a sequence number and buffered in a small FWFT FIFO.
- A bench, display driver or UART drains the FIFO over a valid/ready handshake.
- Overflow is counted and is visible to the consumer as gaps in the sequence numbers.

---
 rtl/program_out_monitor_pkg.sv | 19 +
 rtl/program_out_monitor_if.sv | 29 ++
 rtl/program_out_monitor_sync_fwft_fifo.sv | 56 +++++
 rtl/program_out_monitor.sv | 93 +++++++++
 tb/tb_program_out_monitor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/program_out_monitor_pkg.sv
// Shared types and defaults for the CPU result-bus monitor.
// State encoding, default sizes and the FIFO entry width.
package program_out_monitor_pkg;

  typedef enum logic [1:0] {
    PMON_IDLE  = 2'd0,
    PMON_PRIME = 2'd1,
    PMON_RUN   = 2'd2
  } pmon_state_e;

  localparam int PMON_DATA_W = 16;
  localparam int PMON_DEPTH  = 8;
  localparam int PMON_SEQ_W  = 8;

  function automatic int entry_w(input int data_w, input int seq_w);
    return 2 * data_w + seq_w;
  endfunction

endpackage

// File: rtl/program_out_monitor_if.sv
// Valid/ready drain port of the monitor FIFO head.
// The monitor drives the master side; the consumer drives ready.
interface program_out_monitor_if
  import program_out_monitor_pkg::*;
#(
  parameter int DATA_W = PMON_DATA_W,
  parameter int SEQ_W  = PMON_SEQ_W
);

  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]    out_seq;

  modport master (
    output out_valid,
    output out_data,
    output out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_seq,
    output out_ready
  );

endinterface

// File: rtl/program_out_monitor_sync_fwft_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers.
// A push into a full FIFO is taken when a pop frees the slot that cycle.
module sync_fwft_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // When empty the head shows the last entry that left.
  assign dout = empty ? hold_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/program_out_monitor.sv
// Captures every change of the CPU result pair with a sequence tag
// and queues it for a valid/ready consumer; drops are counted.
module program_out_monitor
  import program_out_monitor_pkg::*;
#(
  parameter int DATA_W = PMON_DATA_W,
  parameter int DEPTH  = PMON_DEPTH,
  parameter int SEQ_W  = PMON_SEQ_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      program_out,
  input  logic [DATA_W-1:0]      program_out2,
  program_out_monitor_if.master  out_bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [SEQ_W-1:0]       overflow_count
);

  localparam int EW = entry_w(DATA_W, SEQ_W);

  pmon_state_e         state_q;
  pmon_state_e         state_d;
  logic                capture;
  logic [2*DATA_W-1:0] cur;
  logic [2*DATA_W-1:0] last_q;
  logic [SEQ_W-1:0]    seq_q;
  logic [SEQ_W-1:0]    ovf_q;
  logic                full;
  logic                empty;
  logic                pop;
  logic [EW-1:0]       head;

  assign cur = {program_out2, program_out};
  assign pop = out_bus.out_valid && out_bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= PMON_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      PMON_IDLE: begin
        if (enable) state_d = PMON_PRIME;
      end
      PMON_PRIME: begin
        capture = 1'b1;
        state_d = PMON_RUN;
      end
      PMON_RUN: begin
        if (!enable) state_d = PMON_IDLE;
        else         capture = (cur != last_q);
      end
      default: state_d = PMON_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
      seq_q  <= '0;
      ovf_q  <= '0;
    end else if (capture) begin
      last_q <= cur;
      seq_q  <= seq_q + 1'b1;
      if (full && !pop && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .din   ({cur, seq_q}),
    .full  (full),
    .empty (empty),
    .dout  (head),
    .level (level)
  );

  assign out_bus.out_valid = !empty;
  assign out_bus.out_data  = head[EW-1:SEQ_W];
  assign out_bus.out_seq   = head[SEQ_W-1:0];
  assign overflow_count    = ovf_q;

endmodule

// File: tb/tb_program_out_monitor.sv
// Scoreboard bench for program_out_monitor: stimulus queues expected
// entries, a forked monitor checks each accepted head.
module tb_program_out_monitor;
  import program_out_monitor_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] po;
  logic [15:0] po2;
  logic [3:0]  level;
  logic [7:0]  ovf;

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q [$];

  program_out_monitor_if #(.DATA_W(16), .SEQ_W(8)) bus ();

  program_out_monitor dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .program_out    (po),
    .program_out2   (po2),
    .out_bus        (bus),
    .level          (level),
    .overflow_count (ovf)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [31:0] d, input logic [7:0] s);
    exp_q.push_back({d, s});
  endtask

  task automatic monitor_loop();
    logic [39:0] e;
    forever begin
      @(negedge clock);
      if (reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected got=%h want=none",
                   {bus.out_data, bus.out_seq});
        end else begin
          e = exp_q.pop_front();
          chk("pop_entry", {bus.out_data, bus.out_seq}, e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    po = '0;
    po2 = '0;
    bus.out_ready = 1'b0;
    fork
      monitor_loop();
    join_none
    tick();
    chk("rst_level", 40'(level), 40'd0);
    chk("rst_valid", 40'(bus.out_valid), 40'd0);
    chk("rst_data", 40'(bus.out_data), 40'd0);
    chk("rst_seq", 40'(bus.out_seq), 40'd0);
    chk("rst_ovf", 40'(ovf), 40'd0);
    reset = 1'b1;
    tick();

    // PRIME capture of all-zero inputs
    enable = 1'b1;
    expect_entry(32'h0, 8'd0);
    tick();
    chk("idle_no_push", 40'(level), 40'd0);
    tick();
    chk("prime_level", 40'(level), 40'd1);
    chk("prime_valid", 40'(bus.out_valid), 40'd1);
    tick();
    chk("prime_hold", 40'(level), 40'd1);

    // streaming with ready high
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      po = 16'(i);
      expect_entry(32'(i), 8'(i));
      tick();
      chk("stream_level", 40'(level <= 4'd1), 40'd1);
    end
    tick();
    tick();
    chk("stream_drained", 40'(level), 40'd0);
    chk("empty_hold_data", 40'(bus.out_data), 40'h3);
    chk("empty_hold_seq", 40'(bus.out_seq), 40'd3);

    // restart and overflow
    bus.out_ready = 1'b0;
    enable = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    po = 16'h0100;
    enable = 1'b1;
    tick();
    expect_entry(32'h0100, 8'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      po = 16'h0100 + 16'(i);
      if (i <= 7) expect_entry(32'h0100 + 32'(i), 8'(i));
      tick();
    end
    chk("full_level", 40'(level), 40'd8);
    chk("full_ovf", 40'(ovf), 40'd3);

    // capture into full FIFO while popping
    po = 16'h0200;
    bus.out_ready = 1'b1;
    expect_entry(32'h0200, 8'd11);
    tick();
    chk("full_pushpop_level", 40'(level), 40'd8);
    chk("full_pushpop_ovf", 40'(ovf), 40'd3);
    for (int i = 0; i < 8; i++) tick();
    chk("full_drained", 40'(level), 40'd0);

    // queue 4, disable, drain, re-enable
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      po = 16'h0300 + 16'(i);
      expect_entry(32'h0300 + 32'(i), 8'd12 + 8'(i));
      tick();
    end
    chk("queued4", 40'(level), 40'd4);
    enable = 1'b0;
    po = 16'h0400;
    tick();
    po = 16'h0401;
    tick();
    po = 16'h0303;
    tick();
    chk("disabled_no_capture", 40'(level), 40'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("disabled_drained", 40'(level), 40'd0);
    bus.out_ready = 1'b0;
    enable = 1'b1;
    expect_entry(32'h0303, 8'd16);
    tick();
    tick();
    chk("reprime_level", 40'(level), 40'd1);
    tick();
    tick();
    chk("reprime_once", 40'(level), 40'd1);

    // async reset mid-stream at level 5
    for (int i = 0; i < 4; i++) begin
      po = 16'h0500 + 16'(i);
      tick();
    end
    chk("pre_reset_level", 40'(level), 40'd5);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 40'(bus.out_valid), 40'd0);
    chk("async_level", 40'(level), 40'd0);
    chk("async_ovf", 40'(ovf), 40'd0);
    chk("async_data", 40'(bus.out_data), 40'd0);
    exp_q.delete();
    enable = 1'b0;
    reset = 1'b1;

    // sequence restarts with both buses driven
    po = 16'h0600;
    po2 = 16'hABCD;
    bus.out_ready = 1'b1;
    enable = 1'b1;
    expect_entry(32'hABCD_0600, 8'd0);
    tick();
    tick();
    tick();
    tick();
    chk("restart_drained", 40'(level), 40'd0);
    chk("scoreboard_empty", 40'(exp_q.size()), 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
